uart_link_responder: RTL and testbench
======================================

// Module: uart_link_responder
// PURPOSE
//  Far-end responder of the UART acknowledged-byte link: receives data bytes from a UART RX, returns ACK byte 0xCC
//  per accepted byte, buffers bytes in a small FIFO and replays each as a single-byte bus-master write.
//  Withholding ACK when full is the flow control (sender retries on its timeout). Received 0xCC = peer ACK, flagged only.
// PARAMETERS
//  SLAVE_LEN     2      width of m_slave_select
//  ADDR_LEN      12     width of m_address
//  DATA_LEN      8      UART/bus data width
//  BURST_LEN     12     width of m_burst_num
//  FIFO_DEPTH    4      receive buffer entries (power of 2)
//  TARGET_SLAVE  1      slave select driven on every write
//  TARGET_ADDR   0      address driven on every write
// PORTS
//  clk             in   1            system clock
//  reset_n         in   1            async active-low reset
//  u_receive_sig   in   1            1-cycle pulse: u_data_in valid
//  u_data_in       in   DATA_LEN     received UART byte
//  u_tx_busy       in   1            UART TX busy
//  u_tx_done       in   1            1-cycle pulse: TX byte finished
//  u_send_sig      out  1            1-cycle start pulse to UART TX
//  u_data_out      out  DATA_LEN     byte to UART TX
//  m_tx_done       in   1            bus master finished current op
//  m_instruction   out  2            2'b00 idle, 2'b10 write
//  m_slave_select  out  SLAVE_LEN    target slave
//  m_address       out  ADDR_LEN     target address
//  m_data_out      out  DATA_LEN     write data
//  m_burst_num     out  BURST_LEN    always 0 (single byte)
//  ack_seen        out  1            1-cycle pulse: peer ACK (0xCC) received
//  drop_count      out  8            bytes refused (FIFO full), saturates 255
//  fifo_level      out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, reset_n=0): m_instruction 00, m_slave_select TARGET_SLAVE, m_address TARGET_ADDR, m_data_out 0,
//   m_burst_num 0, u_send_sig 0, u_data_out 0, ack_seen 0, drop_count 0; FIFO emptied; pending ACKs discarded;
//   FSMs to idle. Reset mid-operation abandons any write/ACK in flight.
//  RX classify (edge where u_receive_sig=1): byte==0xCC -> ack_seen=1 next cycle only, no push, no ACK.
//   else if FIFO not full -> push, ack_pending+1. else -> drop, drop_count+1 (sat.), no ACK.
//   Full is evaluated before a same-cycle pop: push while full is refused even if a pop occurs.
//  ack_pending: 2-bit counter, saturates at 3; simultaneous inc/dec leaves it unchanged.
//  ACK FSM: A_IDLE: ack_pending>0 && !u_tx_busy -> u_send_sig=1 (one cycle), u_data_out=0xCC, go A_WAIT.
//   A_WAIT: u_send_sig=0; on u_tx_done -> ack_pending-1, A_IDLE. Never issues u_send_sig while u_tx_busy=1.
//  Master FSM: M_IDLE: FIFO not empty -> pop head, m_data_out=head, m_instruction=10, select/addr=targets,
//   m_burst_num=0, go M_WRITE. M_WRITE: hold all outputs; on m_tx_done -> m_instruction=00, M_IDLE.
//   At least one M_IDLE cycle between writes. Byte order preserved.
//  Latency: u_receive_sig sampled at edge N (empty FIFO, M_IDLE) -> m_instruction=10 valid after edge N+1;
//   u_send_sig asserted after edge N+1 if TX idle.
//  Effective capacity: FIFO_DEPTH queued + 1 in master stage.
//  FIFO pointers wrap modulo FIFO_DEPTH; fifo_level in 0..FIFO_DEPTH.
// STRUCTURE
//  Package uart_link_pkg: ACK_BYTE=8'hCC, INSTR_IDLE=2'b00, INSTR_WRITE=2'b10, ack_state_t {A_IDLE,A_WAIT},
//   mst_state_t {M_IDLE,M_WRITE}; shared with the initiator-side bridge.
//  Sub-module link_fifo (DEPTH, WIDTH): sync FIFO, push/pop/full/empty/level, async active-low clear.
// TESTING
//  1 Rx 0x5A, TX idle -> one u_send_sig pulse with u_data_out 0xCC; m_instruction=10, m_data_out 0x5A held
//    until m_tx_done, then 00; fifo_level back to 0.
//  2 Rx 0xCC -> ack_seen high exactly 1 cycle; no u_send_sig; m_instruction stays 00.
//  3 m_tx_done held 0, Rx 0x01..0x06 -> 5 ACKs, 0x06 unacked, drop_count=1, fifo_level=4; release
//    m_tx_done -> writes 0x01..0x05 in order.
//  4 u_tx_busy=1 when 0x33 arrives -> u_send_sig withheld; first cycle after busy falls -> pulse with 0xCC.
//  5 reset_n low during M_WRITE with 2 bytes queued -> outputs at reset values same cycle, fifo_level 0,
//    no ACK or write after reset_n returns high.
//  6 300 refused bytes with FIFO full -> drop_count stops at 255.

Source files
------------

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - Shared constants and state types for the UART acknowledged-byte link
package uart_link_pkg;

  localparam logic [7:0] ACK_BYTE    = 8'hCC;
  localparam logic [1:0] INSTR_IDLE  = 2'b00;
  localparam logic [1:0] INSTR_WRITE = 2'b10;

  typedef enum logic {A_IDLE, A_WAIT} ack_state_t;
  typedef enum logic {M_IDLE, M_WRITE} mst_state_t;

endpackage

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - Synchronous receive FIFO with occupancy level and async active-low clear
module link_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not cleared; the level counter alone defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/uart_link_responder.sv
// rtl/uart_link_responder.sv - Far-end link responder: ACKs received bytes and replays them as bus writes
module uart_link_responder
  import uart_link_pkg::*;
#(
  parameter int SLAVE_LEN    = 2,
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int BURST_LEN    = 12,
  parameter int FIFO_DEPTH   = 4,
  parameter int TARGET_SLAVE = 1,
  parameter int TARGET_ADDR  = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          u_receive_sig,
  input  logic [DATA_LEN-1:0]           u_data_in,
  input  logic                          u_tx_busy,
  input  logic                          u_tx_done,
  output logic                          u_send_sig,
  output logic [DATA_LEN-1:0]           u_data_out,
  input  logic                          m_tx_done,
  output logic [1:0]                    m_instruction,
  output logic [SLAVE_LEN-1:0]          m_slave_select,
  output logic [ADDR_LEN-1:0]           m_address,
  output logic [DATA_LEN-1:0]           m_data_out,
  output logic [BURST_LEN-1:0]          m_burst_num,
  output logic                          ack_seen,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  ack_state_t          ack_state;
  mst_state_t          mst_state;
  logic [1:0]          ack_pending;
  logic                rx_is_ack;
  logic                rx_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                ack_dec;
  logic [DATA_LEN-1:0] fifo_head;

  assign rx_is_ack = u_receive_sig && (u_data_in == DATA_LEN'(ACK_BYTE));
  assign rx_data   = u_receive_sig && (u_data_in != DATA_LEN'(ACK_BYTE));
  // Full is judged before any same-cycle pop, so a byte arriving while full is refused.
  assign fifo_push = rx_data && !fifo_full;
  assign fifo_pop  = (mst_state == M_IDLE) && !fifo_empty;
  assign ack_dec   = (ack_state == A_WAIT) && u_tx_done;

  assign m_slave_select = SLAVE_LEN'(TARGET_SLAVE);
  assign m_address      = ADDR_LEN'(TARGET_ADDR);
  assign m_burst_num    = '0;

  link_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_LEN)
  ) u_fifo (
    .clk       (clk),
    .clr_n     (reset_n),
    .push      (fifo_push),
    .push_data (u_data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_seen    <= 1'b0;
      drop_count  <= '0;
      ack_pending <= '0;
    end else begin
      ack_seen <= rx_is_ack;
      if (rx_data && fifo_full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (fifo_push && !ack_dec && ack_pending != 2'd3)      ack_pending <= ack_pending + 2'd1;
      else if (ack_dec && !fifo_push && ack_pending != 2'd0) ack_pending <= ack_pending - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_state  <= A_IDLE;
      u_send_sig <= 1'b0;
      u_data_out <= '0;
    end else begin
      u_send_sig <= 1'b0;
      case (ack_state)
        A_IDLE: begin
          if (ack_pending != 2'd0 && !u_tx_busy) begin
            u_send_sig <= 1'b1;
            u_data_out <= DATA_LEN'(ACK_BYTE);
            ack_state  <= A_WAIT;
          end
        end
        A_WAIT: begin
          if (u_tx_done) ack_state <= A_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mst_state     <= M_IDLE;
      m_instruction <= INSTR_IDLE;
      m_data_out    <= '0;
    end else begin
      case (mst_state)
        M_IDLE: begin
          if (!fifo_empty) begin
            m_data_out    <= fifo_head;
            m_instruction <= INSTR_WRITE;
            mst_state     <= M_WRITE;
          end
        end
        M_WRITE: begin
          if (m_tx_done) begin
            m_instruction <= INSTR_IDLE;
            mst_state     <= M_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link_responder.sv
// tb/tb_uart_link_responder.sv - Self-checking bench for uart_link_responder with TX and bus-master models
module tb_uart_link_responder;
  import uart_link_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TX_CYC = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        u_receive_sig;
  logic [7:0]  u_data_in;
  logic        u_tx_busy;
  logic        u_tx_done;
  logic        u_send_sig;
  logic [7:0]  u_data_out;
  logic        m_tx_done;
  logic [1:0]  m_instruction;
  logic [1:0]  m_slave_select;
  logic [11:0] m_address;
  logic [7:0]  m_data_out;
  logic [11:0] m_burst_num;
  logic        ack_seen;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  logic tx_busy_i, force_busy, m_hold;
  int   tx_cnt, mcnt, m_max;
  logic mbusy;
  logic [7:0] cur_wr;

  int passed = 0, total = 0;
  int send_hi = 0, send_bad = 0, seen_hi = 0, tgt_bad = 0, hold_bad = 0;
  int n_acc, n_cc, n_ref;
  logic [7:0] exp_wr[$];
  logic [7:0] got_wr[$];

  typedef struct {
    logic [7:0] data;
    int         exp_acks;
    int         exp_writes;
    int         exp_seen;
  } vec_t;
  vec_t vecs[6];

  assign u_tx_busy = tx_busy_i | force_busy;

  always #5 clk = ~clk;

  uart_link_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .u_receive_sig  (u_receive_sig),
    .u_data_in      (u_data_in),
    .u_tx_busy      (u_tx_busy),
    .u_tx_done      (u_tx_done),
    .u_send_sig     (u_send_sig),
    .u_data_out     (u_data_out),
    .m_tx_done      (m_tx_done),
    .m_instruction  (m_instruction),
    .m_slave_select (m_slave_select),
    .m_address      (m_address),
    .m_data_out     (m_data_out),
    .m_burst_num    (m_burst_num),
    .ack_seen       (ack_seen),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // UART TX: busy for TX_CYC cycles after each start pulse, then a done pulse.
  initial begin
    tx_busy_i = 1'b0; u_tx_done = 1'b0; tx_cnt = 0;
    forever begin
      @(posedge clk); #1;
      u_tx_done = 1'b0;
      if (!reset_n) begin
        tx_busy_i = 1'b0; tx_cnt = 0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin tx_busy_i = 1'b0; u_tx_done = 1'b1; end
      end else if (u_send_sig) begin
        tx_busy_i = 1'b1; tx_cnt = TX_CYC;
      end
    end
  end

  // Bus master: logs each write at its start, completes after a random delay unless held.
  initial begin
    m_tx_done = 1'b0; mbusy = 1'b0; mcnt = 0; cur_wr = '0;
    forever begin
      @(posedge clk); #1;
      m_tx_done = 1'b0;
      if (!reset_n || m_instruction != INSTR_WRITE) begin
        mbusy = 1'b0;
      end else if (!mbusy) begin
        mbusy  = 1'b1;
        mcnt   = $urandom_range(0, m_max);
        cur_wr = m_data_out;
        got_wr.push_back(m_data_out);
        if (m_slave_select != 2'd1 || m_address != 12'd0 || m_burst_num != 12'd0) tgt_bad++;
      end else begin
        if (m_data_out != cur_wr) hold_bad++;
        if (mcnt > 0) mcnt--;
        else if (!m_hold) m_tx_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (u_send_sig) begin
        send_hi++;
        if (u_data_out != 8'hCC) send_bad++;
      end
      if (ack_seen) seen_hi++;
    end
  end

  task automatic clear_model();
    n_acc = 0; n_cc = 0; n_ref = 0;
    exp_wr.delete(); got_wr.delete();
    send_hi = 0; seen_hi = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0; u_receive_sig = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    clear_model();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Reference: a byte is accepted when queued bytes (accepted minus writes started) < DEPTH.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    u_receive_sig = 1'b1; u_data_in = b;
    if (b == 8'hCC) n_cc++;
    else if (n_acc - got_wr.size() < DEPTH) begin n_acc++; exp_wr.push_back(b); end
    else n_ref++;
    @(posedge clk); #2;
    u_receive_sig = 1'b0;
  endtask

  function automatic int wr_mismatches();
    int bad = 0;
    if (got_wr.size() != exp_wr.size()) return 1000;
    foreach (exp_wr[i]) if (got_wr[i] != exp_wr[i]) bad++;
    return bad;
  endfunction

  initial begin
    int s0, w0, a0, bad;
    logic [7:0] b;
    reset_n = 1'b0; u_receive_sig = 1'b0; u_data_in = '0;
    force_busy = 1'b0; m_hold = 1'b0; m_max = 0;
    clear_model();
    do_reset();

    @(negedge clk);
    check("rst_instr", m_instruction, 0);
    check("rst_slave", m_slave_select, 1);
    check("rst_addr", m_address, 0);
    check("rst_mdata", m_data_out, 0);
    check("rst_burst", m_burst_num, 0);
    check("rst_send", u_send_sig, 0);
    check("rst_udata", u_data_out, 0);
    check("rst_ack_seen", ack_seen, 0);
    check("rst_drop", drop_count, 0);
    check("rst_level", fifo_level, 0);

    // Single byte: latency, ACK, held write.
    m_hold = 1'b1;
    @(posedge clk); #2;
    u_receive_sig = 1'b1; u_data_in = 8'h5A; n_acc++; exp_wr.push_back(8'h5A);
    @(posedge clk); #2;
    u_receive_sig = 1'b0;
    @(negedge clk);
    check("t1_level_n", fifo_level, 1);
    check("t1_instr_n", m_instruction, 0);
    check("t1_send_n", u_send_sig, 0);
    @(negedge clk);
    check("t1_instr_n1", m_instruction, 2);
    check("t1_mdata_n1", m_data_out, 8'h5A);
    check("t1_send_n1", u_send_sig, 1);
    check("t1_udata_n1", u_data_out, 8'hCC);
    check("t1_level_n1", fifo_level, 0);
    idle(10); @(negedge clk);
    check("t1_instr_held", m_instruction, 2);
    check("t1_mdata_held", m_data_out, 8'h5A);
    check("t1_ack_count", send_hi, 1);
    m_hold = 1'b0;
    idle(5); @(negedge clk);
    check("t1_instr_done", m_instruction, 0);
    check("t1_writes", wr_mismatches(), 0);

    vecs[0] = '{8'h00, 1, 1, 0};
    vecs[1] = '{8'hCC, 0, 0, 1};
    vecs[2] = '{8'hFF, 1, 1, 0};
    vecs[3] = '{8'hCB, 1, 1, 0};
    vecs[4] = '{8'hCD, 1, 1, 0};
    vecs[5] = '{8'hCC, 0, 0, 1};
    m_max = 3;
    for (int i = 0; i < 6; i++) begin
      s0 = send_hi; w0 = got_wr.size(); a0 = seen_hi;
      send_byte(vecs[i].data);
      idle(20); @(negedge clk);
      check($sformatf("vec%0d_acks", i), send_hi - s0, vecs[i].exp_acks);
      check($sformatf("vec%0d_writes", i), got_wr.size() - w0, vecs[i].exp_writes);
      check($sformatf("vec%0d_seen", i), seen_hi - a0, vecs[i].exp_seen);
      check($sformatf("vec%0d_instr", i), m_instruction, 0);
      if (vecs[i].exp_writes == 1 && got_wr.size() > w0)
        check($sformatf("vec%0d_wdata", i), got_wr[got_wr.size()-1], vecs[i].data);
    end

    // Overflow with master stalled: capacity DEPTH queued plus one in the master stage.
    m_hold = 1'b1; m_max = 0;
    s0 = send_hi; w0 = got_wr.size();
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i));
      idle(8);
    end
    @(negedge clk);
    check("t3_acks", send_hi - s0, 5);
    check("t3_drop", drop_count, 1);
    check("t3_level", fifo_level, 4);
    check("t3_started", got_wr.size() - w0, 1);
    m_hold = 1'b0; m_max = 2;
    idle(60); @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (got_wr.size() < w0 + 5 || got_wr[w0+i] != 8'(i + 1)) bad++;
    check("t3_order", bad, 0);
    check("t3_level_end", fifo_level, 0);
    check("t3_model", wr_mismatches(), 0);

    // ACK withheld while TX busy.
    force_busy = 1'b1;
    s0 = send_hi;
    send_byte(8'h33);
    idle(10); @(negedge clk);
    check("t4_withheld", send_hi - s0, 0);
    @(posedge clk); #2 force_busy = 1'b0;
    @(negedge clk);
    check("t4_not_early", u_send_sig, 0);
    @(negedge clk);
    check("t4_send", u_send_sig, 1);
    check("t4_udata", u_data_out, 8'hCC);
    idle(20);

    // Reset during a write with two bytes queued and ACKs pending.
    force_busy = 1'b1; m_hold = 1'b1; m_max = 0;
    send_byte(8'h11); idle(3);
    send_byte(8'h22); idle(3);
    send_byte(8'h33); idle(3);
    @(negedge clk);
    check("t5_level_pre", fifo_level, 2);
    check("t5_instr_pre", m_instruction, 2);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("t5_instr_rst", m_instruction, 0);
    check("t5_mdata_rst", m_data_out, 0);
    check("t5_send_rst", u_send_sig, 0);
    check("t5_udata_rst", u_data_out, 0);
    check("t5_level_rst", fifo_level, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    clear_model();
    force_busy = 1'b0; m_hold = 1'b0;
    idle(30); @(negedge clk);
    check("t5_no_ack", send_hi, 0);
    check("t5_no_write", got_wr.size(), 0);

    // Drop counter saturation.
    m_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin send_byte(8'h70 + 8'(i)); idle(8); end
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hCC) b = 8'h00;
      send_byte(b);
      if (i == 253) begin
        @(negedge clk);
        check("t6_drop_254", drop_count, 254);
      end
    end
    @(negedge clk);
    check("t6_drop_sat", drop_count, 255);
    check("t6_model_ref", n_ref, 300);
    m_hold = 1'b0;
    idle(60); @(negedge clk);
    check("t6_writes", wr_mismatches(), 0);

    // Randomized traffic against the reference model.
    do_reset();
    m_max = 12;
    for (int i = 0; i < 150; i++) begin
      m_hold = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0) ? 8'hCC : 8'($urandom_range(0, 255));
      send_byte(b);
      idle($urandom_range(6, 10));
    end
    m_hold = 1'b0;
    idle(120); @(negedge clk);
    check("rnd_writes", wr_mismatches(), 0);
    check("rnd_acks", send_hi, n_acc);
    check("rnd_seen", seen_hi, n_cc);
    check("rnd_drop", drop_count, (n_ref > 255) ? 255 : n_ref);
    check("rnd_level", fifo_level, 0);
    check("rnd_instr", m_instruction, 0);
    check("ack_byte_bad", send_bad, 0);
    check("target_bad", tgt_bad, 0);
    check("hold_bad", hold_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
